agc_loop_ctrl: RTL and testbench
================================

Name: agc_loop_ctrl

Overview:
- Gain-loop controller placed ahead of the AGC datapath. It estimates the mean absolute level of the sfix13_En6 input stream over fixed windows and compares that level against a programmable reference.
- After each window it steps an unsigned gain word up or down, using a fast step while acquiring and a slow step once locked.
- It also handles hold (freeze) and restart sequencing for the AGC multiplier.

Parameters:
- WIN_LOG2, 6, log2 of window length in accepted samples (window = 2^WIN_LOG2).
- GAIN_INIT, 16'h1000, gain loaded on reset / run deassert (ufix16_En12, 1.0).
- GAIN_MIN, 16'h0100, lower gain clamp (0.0625).
- GAIN_MAX, 16'hFFFF, upper gain clamp.
- STEP_FAST, 16'h0080, gain step in ACQUIRE.
- STEP_SLOW, 16'h0010, gain step in TRACK.
- LOCK_CNT, 4, consecutive windows needed to enter or leave TRACK (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_enable  in  1  sample qualifier; in_sample is accepted only when high
- run  in  1  level; 0 forces IDLE
- hold  in  1  level; freezes gain and discards the partial window
- in_sample  in  13  input sample, sfix13_En6
- ref_level  in  12  target mean |x|, ufix12_En6
- tol  in  12  deadband half-width, ufix12_En6
- gain  out  16  gain to AGC multiplier, ufix16_En12
- gain_valid  out  1  one-cycle pulse when gain is updated
- locked  out  1  high in TRACK
- state  out  2  0 IDLE, 1 ACQUIRE, 2 TRACK, 3 HOLD

Behaviour:
- Reset is synchronous, active-high and has top priority. Reset values: gain=GAIN_INIT, gain_valid=0, locked=0, state=IDLE. The accumulator, window counter and band counter are cleared.
- Priority below reset: run=0, then hold, then window processing.
- Magnitude:
  - |x| = abs(in_sample), 12 bits unsigned.
  - -4096 saturates to 4095.
- Accumulation:
  - Accumulator is 12+WIN_LOG2 bits, unsigned, and cannot overflow.
  - It adds |x| only on edges with clk_enable=1 in ACQUIRE or TRACK.
  - The window counter wraps at 2^WIN_LOG2.
- Window end (edge k accepts the last sample):
  - mean = acc >> WIN_LOG2 (truncate).
  - hi = ref_level + tol, computed at 13 bits, no wrap.
  - lo = ref_level - tol, clamped at 0.
- Gain update at edge k+1:
  - mean > hi: gain -= step, clamped at GAIN_MIN.
  - mean < lo: gain += step, clamped at GAIN_MAX.
  - Otherwise (in band): gain unchanged.
  - step is STEP_FAST in ACQUIRE and STEP_SLOW in TRACK.
  - gain_valid=1 for exactly the cycle after edge k+1, including when gain is unchanged.
  - A sample accepted at edge k+1 starts the new window.
- Band counter (4 bits) counts consecutive windows that are in band (ACQUIRE) or out of band (TRACK). It resets to 0 on the opposite outcome and on every state change.
- State machine:
  - IDLE: gain held at GAIN_INIT, no accumulation. Goes to ACQUIRE when run=1 and hold=0.
  - ACQUIRE: goes to TRACK on the update edge of the LOCK_CNT-th consecutive in-band window. The step applied on that edge is STEP_FAST, i.e. zero since the window is in band.
  - TRACK: goes to ACQUIRE on the update edge of the LOCK_CNT-th consecutive out-of-band window. That window's step is STEP_SLOW.
  - HOLD: entered from ACQUIRE or TRACK when hold=1. The origin state is stored. Gain is frozen; accumulator, window counter and band counter are cleared. On hold=0 the block returns to the stored state and starts a fresh window.
- Simultaneous events:
  - hold=1 on edge k or k+1: the pending update is cancelled and gain_valid stays 0.
  - run=0 in any state: IDLE next edge, gain=GAIN_INIT, all counters cleared, pending update cancelled.
  - hold=1 while run=1 in IDLE: stay in IDLE.
- Gaps in clk_enable stall the window; partial sums are retained.
- locked = (state==TRACK), registered with state.

Test Plan (WIN_LOG2=2, LOCK_CNT=4, ref_level=0x040, tol=0x004):
- Reset sequence: assert reset for 3 cycles -> gain=0x1000, state=0, gain_valid=0, locked=0; run=1 with reset=1 -> stays IDLE.
- run=1, four accepted samples of 0x080 -> mean 128 > 68; one cycle after the 4th sample gain=0x0F80 and gain_valid pulses once; state=1.
- Continuous 13'h1000 (-4096) samples -> |x| reads 4095; gain decrements by 0x80 per window to 0x0100 and stays there (GAIN_MIN clamp); 16'hFF80-style wrap never appears.
- Alternating 0x040/-0x040 -> 4 in-band windows with gain unchanged; locked=1 after the 4th update; then 0x050 samples -> gain drops by 0x0010 per window; after 4 such windows state returns to 1.
- hold=1 on the edge accepting the 4th sample -> no gain_valid, gain unchanged, state=3; hold=0 -> back to the prior state, and 4 new samples are required before the next update.
- clk_enable toggles 1,0,0,1,0,1,1 with sample values changing during the low cycles -> only the 4 qualified samples are summed and the update timing follows the 4th enabled edge; run=0 mid-window -> IDLE, gain=0x1000.

Source files
------------

// File: rtl/agc_loop_ctrl.sv
// agc_loop_ctrl: windowed mean-|x| level detector and gain stepping loop
// for the AGC multiplier. Gain steps fast while acquiring, slow once
// locked, and can be frozen (hold) or restarted (run low) at any time.
//
// Output handshake: gain_valid is a one-cycle strobe with no ready; it is
// high for exactly the cycle after an update edge, and gain is stable and
// meaningful whenever gain_valid is high (and between strobes).
module agc_loop_ctrl #(
    parameter int          WIN_LOG2  = 6,
    parameter logic [15:0] GAIN_INIT = 16'h1000,
    parameter logic [15:0] GAIN_MIN  = 16'h0100,
    parameter logic [15:0] GAIN_MAX  = 16'hFFFF,
    parameter logic [15:0] STEP_FAST = 16'h0080,
    parameter logic [15:0] STEP_SLOW = 16'h0010,
    parameter int          LOCK_CNT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        run,
    input  logic        hold,
    input  logic [12:0] in_sample,
    input  logic [11:0] ref_level,
    input  logic [11:0] tol,
    output logic [15:0] gain,
    output logic        gain_valid,
    output logic        locked,
    output logic [1:0]  state
);

    localparam int ACC_W = 12 + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] WIN_ONE  = 1;
    localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;
    localparam logic [3:0]          LOCK_L   = 4'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              ret_q;       // state to resume after HOLD
    logic [15:0]         gain_q;
    logic                gain_valid_q;
    logic                locked_q;
    logic [ACC_W-1:0]    acc_q;
    logic [WIN_LOG2-1:0] win_cnt_q;
    logic [3:0]          band_cnt_q;
    logic                pend_q;      // a window closed on the previous edge
    logic                pend_hi_q;   // that window's mean was above band
    logic                pend_lo_q;   // that window's mean was below band

    logic [11:0]         neg_d;
    logic [11:0]         mag_d;
    logic                accept_d;
    logic [ACC_W-1:0]    acc_sum_d;
    logic                win_end_d;
    logic [11:0]         mean_d;
    logic [12:0]         hi_d;
    logic [11:0]         lo_d;
    logic                above_d;
    logic                below_d;
    logic [15:0]         step_d;
    logic [16:0]         gain_sum_d;
    logic [16:0]         dn_floor_d;
    logic [15:0]         gain_up_d;
    logic [15:0]         gain_dn_d;
    logic [3:0]          band_inc_d;
    logic                in_band_d;

    // Magnitude, window accumulation, band thresholds and clamped gain steps
    always_comb begin
        neg_d = 12'd0 - in_sample[11:0];
        if (!in_sample[12]) begin
            mag_d = in_sample[11:0];
        end else if (in_sample[11:0] == 12'd0) begin
            mag_d = 12'hFFF;          // -4096 has no 12-bit magnitude; saturate
        end else begin
            mag_d = neg_d;
        end

        accept_d  = clk_enable && run && !hold &&
                    ((state_q == ST_ACQ) || (state_q == ST_TRACK));
        acc_sum_d = acc_q + {{WIN_LOG2{1'b0}}, mag_d};
        win_end_d = accept_d && (win_cnt_q == WIN_LAST);
        mean_d    = acc_sum_d[ACC_W-1:WIN_LOG2];

        hi_d      = {1'b0, ref_level} + {1'b0, tol};
        lo_d      = (ref_level >= tol) ? (ref_level - tol) : 12'd0;
        above_d   = {1'b0, mean_d} > hi_d;
        below_d   = mean_d < lo_d;

        step_d     = (state_q == ST_TRACK) ? STEP_SLOW : STEP_FAST;
        gain_sum_d = {1'b0, gain_q} + {1'b0, step_d};
        dn_floor_d = {1'b0, step_d} + {1'b0, GAIN_MIN};
        gain_up_d  = (gain_sum_d > {1'b0, GAIN_MAX}) ? GAIN_MAX : gain_sum_d[15:0];
        gain_dn_d  = ({1'b0, gain_q} < dn_floor_d) ? GAIN_MIN : (gain_q - step_d);

        band_inc_d = band_cnt_q + 4'd1;
        in_band_d  = !pend_hi_q && !pend_lo_q;
    end

    // Loop state machine: sequencing, accumulation, gain update, lock tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ret_q        <= ST_IDLE;
            gain_q       <= GAIN_INIT;
            gain_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            acc_q        <= '0;
            win_cnt_q    <= '0;
            band_cnt_q   <= '0;
            pend_q       <= 1'b0;
            pend_hi_q    <= 1'b0;
            pend_lo_q    <= 1'b0;
        end else if (!run) begin
            state_q      <= ST_IDLE;
            gain_q       <= GAIN_INIT;
            gain_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            acc_q        <= '0;
            win_cnt_q    <= '0;
            band_cnt_q   <= '0;
            pend_q       <= 1'b0;
        end else begin
            gain_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    gain_q <= GAIN_INIT;
                    if (!hold) begin
                        state_q <= ST_ACQ;
                    end
                end
                ST_HOLD: begin
                    if (!hold) begin
                        state_q  <= ret_q;
                        locked_q <= (ret_q == ST_TRACK);
                    end
                end
                default: begin
                    if (hold) begin
                        // Freeze gain, drop the partial window and any pending update
                        ret_q      <= state_q;
                        state_q    <= ST_HOLD;
                        locked_q   <= 1'b0;
                        acc_q      <= '0;
                        win_cnt_q  <= '0;
                        band_cnt_q <= '0;
                        pend_q     <= 1'b0;
                    end else begin
                        pend_q <= win_end_d;
                        if (win_end_d) begin
                            acc_q     <= '0;
                            win_cnt_q <= '0;
                            pend_hi_q <= above_d;
                            pend_lo_q <= below_d;
                        end else if (accept_d) begin
                            acc_q     <= acc_sum_d;
                            win_cnt_q <= win_cnt_q + WIN_ONE;
                        end

                        if (pend_q) begin
                            gain_valid_q <= 1'b1;
                            if (pend_hi_q) begin
                                gain_q <= gain_dn_d;
                            end else if (pend_lo_q) begin
                                gain_q <= gain_up_d;
                            end

                            if (state_q == ST_ACQ) begin
                                if (!in_band_d) begin
                                    band_cnt_q <= 4'd0;
                                end else if (band_inc_d == LOCK_L) begin
                                    band_cnt_q <= 4'd0;
                                    state_q    <= ST_TRACK;
                                    locked_q   <= 1'b1;
                                end else begin
                                    band_cnt_q <= band_inc_d;
                                end
                            end else begin
                                if (in_band_d) begin
                                    band_cnt_q <= 4'd0;
                                end else if (band_inc_d == LOCK_L) begin
                                    band_cnt_q <= 4'd0;
                                    state_q    <= ST_ACQ;
                                    locked_q   <= 1'b0;
                                end else begin
                                    band_cnt_q <= band_inc_d;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign gain       = gain_q;
    assign gain_valid = gain_valid_q;
    assign locked     = locked_q;
    assign state      = state_q;

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// tb_agc_loop_ctrl: directed bench for agc_loop_ctrl with WIN_LOG2=2,
// LOCK_CNT=4, ref_level=0x040, tol=0x004 (band 60..68).
module tb_agc_loop_ctrl;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clk_enable;
    logic        run;
    logic        hold;
    logic [12:0] in_sample;
    logic [11:0] ref_level;
    logic [11:0] tol;
    logic [15:0] gain;
    logic        gain_valid;
    logic        locked;
    logic [1:0]  state;

    agc_loop_ctrl #(
        .WIN_LOG2 (2),
        .LOCK_CNT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .run        (run),
        .hold       (hold),
        .in_sample  (in_sample),
        .ref_level  (ref_level),
        .tol        (tol),
        .gain       (gain),
        .gain_valid (gain_valid),
        .locked     (locked),
        .state      (state)
    );

    int checks = 0;
    int errors = 0;

    // scoreboard: {state[1:0], gain[15:0]} expected at each gain_valid
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // driver tasks
    task automatic tick(input logic en, input logic [12:0] smp);
        clk_enable = en;
        in_sample  = smp;
        @(posedge clk);
        #1;
    endtask

    task automatic send_win(input logic [12:0] a, input logic [12:0] b,
                            input logic [15:0] eg, input logic [1:0] es);
        tick(1'b1, a);
        tick(1'b1, b);
        tick(1'b1, a);
        exp_q.push_back({es, eg});
        tick(1'b1, b);
    endtask

    // monitor
    always @(negedge clk) begin
        if (!reset && gain_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_gain_valid actual gain=%0h state=%0d required no update", gain, state);
            end else begin
                mon_e = exp_q.pop_front();
                check("upd_gain", gain, mon_e[15:0]);
                check("upd_state", state, mon_e[17:16]);
                check("upd_locked", locked, mon_e[17:16] == 2'd2);
            end
        end
    end

    logic [15:0] eg;
    logic [6:0]  en_pat;

    initial begin
        reset      = 1'b1;
        run        = 1'b0;
        hold       = 1'b0;
        clk_enable = 1'b0;
        in_sample  = 13'd0;
        ref_level  = 12'h040;
        tol        = 12'h004;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_gain", gain, 16'h1000);
        check("rst_state", state, 2'd0);
        check("rst_gv", gain_valid, 1'b0);
        check("rst_locked", locked, 1'b0);

        run = 1'b1;
        tick(1'b0, 13'd0);
        check("rst_run_idle", state, 2'd0);

        reset = 1'b0;
        tick(1'b0, 13'd0);
        check("idle_to_acq", state, 2'd1);
        check("acq_gain_init", gain, 16'h1000);

        // mean 128 above band: fast step down
        send_win(13'h0080, 13'h0080, 16'h0F80, 2'd1);

        // +/-64: in band, four windows to lock
        for (int i = 0; i < 4; i++) begin
            send_win(13'h0040, 13'h1FC0, 16'h0F80, (i == 3) ? 2'd2 : 2'd1);
        end

        // 0x050 in TRACK: slow step down, unlock after four windows
        send_win(13'h0050, 13'h0050, 16'h0F70, 2'd2);
        send_win(13'h0050, 13'h0050, 16'h0F60, 2'd2);
        send_win(13'h0050, 13'h0050, 16'h0F50, 2'd2);
        send_win(13'h0050, 13'h0050, 16'h0F40, 2'd1);

        // -4096 saturates to 4095: descend by 0x80 to GAIN_MIN and stay
        eg = 16'h0F40;
        for (int i = 0; i < 31; i++) begin
            eg = (eg >= 16'h0180) ? (eg - 16'h0080) : 16'h0100;
            send_win(13'h1000, 13'h1000, eg, 2'd1);
        end

        // mean 16 below band: fast step up
        send_win(13'h0010, 13'h0010, 16'h0180, 2'd1);

        // hold on the edge accepting the 4th sample cancels the update
        tick(1'b1, 13'h0010);
        tick(1'b1, 13'h0010);
        tick(1'b1, 13'h0010);
        hold = 1'b1;
        tick(1'b1, 13'h0010);
        check("hold_state", state, 2'd3);
        check("hold_gain", gain, 16'h0180);
        check("hold_gv", gain_valid, 1'b0);
        check("hold_locked", locked, 1'b0);
        tick(1'b0, 13'd0);
        tick(1'b0, 13'd0);
        check("hold_stay", state, 2'd3);
        hold = 1'b0;
        tick(1'b0, 13'd0);
        check("hold_return", state, 2'd1);
        tick(1'b1, 13'h0010);
        tick(1'b1, 13'h0010);
        tick(1'b1, 13'h0010);
        tick(1'b0, 13'd0);
        tick(1'b0, 13'd0);
        check("fresh_win_gain", gain, 16'h0180);
        check("fresh_win_gv", gain_valid, 1'b0);
        exp_q.push_back({2'd1, 16'h0200});
        tick(1'b1, 13'h0010);
        check("fresh_k_gv", gain_valid, 1'b0);
        tick(1'b0, 13'd0);
        check("fresh_k1_gv", gain_valid, 1'b1);

        // clk_enable gaps: large values on unqualified cycles are ignored
        en_pat = 7'b1101001;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) exp_q.push_back({2'd1, 16'h0280});
            tick(en_pat[i], en_pat[i] ? 13'h0010 : 13'h0FFF);
        end
        check("gap_k_gv", gain_valid, 1'b0);
        tick(1'b0, 13'h0FFF);
        check("gap_k1_gv", gain_valid, 1'b1);
        check("gap_gain", gain, 16'h0280);

        // run low mid-window: IDLE, gain reload, counters cleared
        tick(1'b1, 13'h0080);
        tick(1'b1, 13'h0080);
        run = 1'b0;
        tick(1'b0, 13'd0);
        check("run0_state", state, 2'd0);
        check("run0_gain", gain, 16'h1000);
        check("run0_locked", locked, 1'b0);
        check("run0_gv", gain_valid, 1'b0);
        run = 1'b1;
        tick(1'b0, 13'd0);
        check("rerun_state", state, 2'd1);
        send_win(13'h0080, 13'h0080, 16'h0F80, 2'd1);
        tick(1'b0, 13'd0);
        tick(1'b0, 13'd0);
        tick(1'b0, 13'd0);

        // final report
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
